// File: rtl/mux_scan_sel.sv
// Registered N-to-1 channel selector with a manual address mode and a
// round-robin auto-scan mode that holds each channel for SCAN_DIV cycles.
module mux_scan_sel #(
  parameter int N_CH     = 8,
  parameter int DW       = 1,
  parameter int SEL_W    = $clog2(N_CH),
  parameter int SCAN_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [N_CH*DW-1:0]   D,
  input  logic [SEL_W-1:0]     addy,
  output logic [DW-1:0]        dout,
  output logic                 valid,
  output logic [SEL_W-1:0]     sel_out,
  output logic                 wrap
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   NCH      = (SEL_W + 1)'(N_CH);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [DIV_W-1:0] div;
  logic [SEL_W-1:0] ptr_nxt;
  logic             addy_ok;

  // Channel lookup by compare rather than a variable part-select, so
  // out-of-range indices simply return zero.
  function automatic logic [DW-1:0] sel_ch(input logic [N_CH*DW-1:0] data,
                                           input logic [SEL_W-1:0] idx);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) r = data[k*DW +: DW];
    end
    return r;
  endfunction

  always_comb begin
    ptr_nxt = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    addy_ok = ({1'b0, addy} < NCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      div     <= '0;
      dout    <= '0;
      valid   <= 1'b0;
      sel_out <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        state <= IDLE;
        ptr   <= '0;
        div   <= '0;
        dout  <= '0;
        valid <= 1'b0;
      end else if (!mode) begin
        state   <= MANUAL;
        sel_out <= addy;
        dout    <= addy_ok ? sel_ch(D, addy) : '0;
        valid   <= addy_ok;
      end else if (state != SCAN) begin
        // Entering scan always restarts at channel 0 with a full hold.
        state   <= SCAN;
        ptr     <= '0;
        div     <= '0;
        dout    <= sel_ch(D, '0);
        sel_out <= '0;
        valid   <= 1'b1;
      end else if (div == DIV_LAST) begin
        div     <= '0;
        ptr     <= ptr_nxt;
        dout    <= sel_ch(D, ptr_nxt);
        sel_out <= ptr_nxt;
        valid   <= 1'b1;
        wrap    <= (ptr == PTR_LAST);
      end else begin
        div     <= div + 1'b1;
        dout    <= sel_ch(D, ptr);
        sel_out <= ptr;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: an 8-channel instance (SCAN_DIV=4) and a
// 5-channel, 2-bit-wide instance (SCAN_DIV=1) for out-of-range addressing.
module tb_mux_scan_sel;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic       rst_n8, en8, mode8;
  logic [7:0] d8;
  logic [2:0] addy8;
  logic       dout8, valid8, wrap8;
  logic [2:0] sel8;

  mux_scan_sel #(.N_CH(8), .DW(1), .SCAN_DIV(4)) u8 (
    .clk(clk), .rst_n(rst_n8), .en(en8), .mode(mode8), .D(d8), .addy(addy8),
    .dout(dout8), .valid(valid8), .sel_out(sel8), .wrap(wrap8)
  );

  // 5-channel instance
  logic       rst_n5, en5, mode5;
  logic [9:0] d5;
  logic [2:0] addy5;
  logic [1:0] dout5;
  logic       valid5, wrap5;
  logic [2:0] sel5;

  mux_scan_sel #(.N_CH(5), .DW(2), .SCAN_DIV(1)) u5 (
    .clk(clk), .rst_n(rst_n5), .en(en5), .mode(mode5), .D(d5), .addy(addy5),
    .dout(dout5), .valid(valid5), .sel_out(sel5), .wrap(wrap5)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected scan output for channel ch of the 8-channel instance.
  task automatic chk_scan8(input string nm, input int ch, input logic w);
    chk({nm, "_dout"}, 32'(dout8), 32'(d8[ch]));
    chk({nm, "_valid"}, 32'(valid8), 32'd1);
    chk({nm, "_sel"}, 32'(sel8), 32'(ch));
    chk({nm, "_wrap"}, 32'(wrap8), 32'(w));
  endtask

  typedef struct {
    logic       rst_n, en, mode;
    logic [2:0] addy;
    logic [7:0] d;
    logic       e_dout, e_valid;
    logic [2:0] e_sel;
    logic       e_wrap;
  } vec_t;

  vec_t tbl[14];

  initial begin
    rst_n8 = 1'b0; en8 = 1'b0; mode8 = 1'b0; addy8 = '0; d8 = 8'hAA;
    rst_n5 = 1'b0; en5 = 1'b0; mode5 = 1'b0; addy5 = '0;
    d5 = {2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

    // reset for 3 cycles, idle with en=0, then manual sweep and enable drop
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'hAA, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'hAA, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'hAA, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'hAA, 1'b0, 1'b0, 3'd0, 1'b0};
    for (int k = 0; k < 8; k++)
      tbl[4+k] = '{1'b1, 1'b1, 1'b0, 3'(k), 8'hAA, k[0], 1'b1, 3'(k), 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 3'd3, 8'hAA, 1'b0, 1'b0, 3'd7, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 3'd5, 8'hAA, 1'b1, 1'b1, 3'd5, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst_n8 = tbl[i].rst_n; en8 = tbl[i].en; mode8 = tbl[i].mode;
      addy8 = tbl[i].addy; d8 = tbl[i].d;
      tick();
      chk($sformatf("vec%0d_dout", i), 32'(dout8), 32'(tbl[i].e_dout));
      chk($sformatf("vec%0d_valid", i), 32'(valid8), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_sel", i), 32'(sel8), 32'(tbl[i].e_sel));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap8), 32'(tbl[i].e_wrap));
    end

    // auto-scan from manual; live data change during a hold at i=34
    mode8 = 1'b1; d8 = 8'hCA; addy8 = 3'd2;
    for (int i = 0; i < 40; i++) begin
      if (i == 34) d8 = 8'h35;
      tick();
      chk_scan8($sformatf("scan%0d", i), (i / 4) % 8, i == 32);
    end

    // en drop mid-scan, then restart from channel 0 up to ptr=5, div=2
    en8 = 1'b0;
    tick();
    chk("endrop_valid", 32'(valid8), 32'd0);
    chk("endrop_dout", 32'(dout8), 32'd0);
    en8 = 1'b1;
    for (int i = 0; i < 23; i++) begin
      tick();
      chk_scan8($sformatf("rescan%0d", i), (i / 4) % 8, 1'b0);
    end

    // reset mid-scan wins, then scan resumes at channel 0 with a full hold
    rst_n8 = 1'b0;
    tick();
    chk("rstmid_dout", 32'(dout8), 32'd0);
    chk("rstmid_valid", 32'(valid8), 32'd0);
    chk("rstmid_sel", 32'(sel8), 32'd0);
    chk("rstmid_wrap", 32'(wrap8), 32'd0);
    rst_n8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_scan8($sformatf("postrst%0d", i), i / 4, 1'b0);
    end

    // mode toggle mid-hold: manual for one edge, back to scan restarts at 0
    mode8 = 1'b0; addy8 = 3'd6;
    tick();
    chk("toggle_man_dout", 32'(dout8), 32'(d8[6]));
    chk("toggle_man_sel", 32'(sel8), 32'd6);
    chk("toggle_man_wrap", 32'(wrap8), 32'd0);
    mode8 = 1'b1;
    tick();
    chk_scan8("toggle_scan0", 0, 1'b0);
    tick();
    chk_scan8("toggle_scan1", 0, 1'b0);

    // 5-channel instance: out-of-range addresses and SCAN_DIV=1 scanning
    tick();
    rst_n5 = 1'b1; en5 = 1'b1; mode5 = 1'b0; addy5 = 3'd6;
    tick();
    chk("oor6_valid", 32'(valid5), 32'd0);
    chk("oor6_dout", 32'(dout5), 32'd0);
    chk("oor6_sel", 32'(sel5), 32'd6);
    addy5 = 3'd4;
    tick();
    chk("addr4_valid", 32'(valid5), 32'd1);
    chk("addr4_dout", 32'(dout5), 32'd3);
    chk("addr4_sel", 32'(sel5), 32'd4);
    addy5 = 3'd5;
    tick();
    chk("oor5_valid", 32'(valid5), 32'd0);
    chk("oor5_dout", 32'(dout5), 32'd0);
    mode5 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("scan5_%0d_sel", i), 32'(sel5), 32'(i % 5));
      chk($sformatf("scan5_%0d_dout", i), 32'(dout5), 32'(d5[(i % 5)*2 +: 2]));
      chk($sformatf("scan5_%0d_valid", i), 32'(valid5), 32'd1);
      chk($sformatf("scan5_%0d_wrap", i), 32'(wrap5), 32'(i == 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
